// File: rtl/turf_udp_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UDP header+payload path among NUM_PORTS senders.
// Optional per-port packet counters when TURF_UDP_ARB_STATS_EN is defined.
module turf_udp_tx_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int PTR_BITS  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [64*NUM_PORTS-1:0]   s_hdr_tdata,
    input  logic [16*NUM_PORTS-1:0]   s_hdr_tuser,
    input  logic [NUM_PORTS-1:0]      s_hdr_tvalid,
    output logic [NUM_PORTS-1:0]      s_hdr_tready,
    input  logic [64*NUM_PORTS-1:0]   s_data_tdata,
    input  logic [8*NUM_PORTS-1:0]    s_data_tkeep,
    input  logic [NUM_PORTS-1:0]      s_data_tlast,
    input  logic [NUM_PORTS-1:0]      s_data_tvalid,
    output logic [NUM_PORTS-1:0]      s_data_tready,
    output logic [63:0]               m_udphdr_tdata,
    output logic [15:0]               m_udphdr_tuser,
    output logic                      m_udphdr_tvalid,
    input  logic                      m_udphdr_tready,
    output logic [63:0]               m_udpdata_tdata,
    output logic [7:0]                m_udpdata_tkeep,
    output logic                      m_udpdata_tlast,
    output logic                      m_udpdata_tvalid,
    input  logic                      m_udpdata_tready,
    output logic [PTR_BITS-1:0]       grant_idx,
    output logic                      busy
`ifdef TURF_UDP_ARB_STATS_EN
    ,
    output logic [32*NUM_PORTS-1:0]   pkt_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_BITS-1:0] grant_q, grant_d;
    logic [PTR_BITS-1:0] last_q, last_d;
    logic [PTR_BITS-1:0] winner;
    logic [PTR_BITS:0]   cand;
    logic                found;
    logic                hdr_fire;
    logic                data_done;

    // Scan last+1, last+2, ... so the most recently served port goes to the back.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = {1'b0, last_q} + (PTR_BITS+1)'(k);
            if (cand >= (PTR_BITS+1)'(NUM_PORTS)) begin
                cand = cand - (PTR_BITS+1)'(NUM_PORTS);
            end
            if (!found && s_hdr_tvalid[cand[PTR_BITS-1:0]]) begin
                found  = 1'b1;
                winner = cand[PTR_BITS-1:0];
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        last_d           = last_q;
        s_hdr_tready     = '0;
        s_data_tready    = '0;
        m_udphdr_tdata   = '0;
        m_udphdr_tuser   = '0;
        m_udphdr_tvalid  = 1'b0;
        m_udpdata_tdata  = '0;
        m_udpdata_tkeep  = '0;
        m_udpdata_tlast  = 1'b0;
        m_udpdata_tvalid = 1'b0;
        hdr_fire         = 1'b0;
        data_done        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = winner;
                    state_d = HDR;
                end
            end
            HDR: begin
                m_udphdr_tdata         = s_hdr_tdata[64*grant_q +: 64];
                m_udphdr_tuser         = s_hdr_tuser[16*grant_q +: 16];
                m_udphdr_tvalid        = s_hdr_tvalid[grant_q];
                s_hdr_tready[grant_q]  = m_udphdr_tready;
                hdr_fire               = m_udphdr_tvalid && m_udphdr_tready;
                if (hdr_fire) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                m_udpdata_tdata        = s_data_tdata[64*grant_q +: 64];
                m_udpdata_tkeep        = s_data_tkeep[8*grant_q +: 8];
                m_udpdata_tlast        = s_data_tlast[grant_q];
                m_udpdata_tvalid       = s_data_tvalid[grant_q];
                s_data_tready[grant_q] = m_udpdata_tready;
                data_done = m_udpdata_tvalid && m_udpdata_tready && m_udpdata_tlast;
                if (data_done) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= PTR_BITS'(NUM_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign grant_idx = grant_q;
    assign busy      = (state_q != IDLE);

`ifdef TURF_UDP_ARB_STATS_EN
    logic [31:0] cnt_q [NUM_PORTS];
    logic [31:0] cnt_d [NUM_PORTS];

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (data_done) begin
            cnt_d[grant_q] = cnt_q[grant_q] + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        pkt_count = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            pkt_count[32*i +: 32] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_turf_udp_tx_arbiter.sv
// Self-checking bench for turf_udp_tx_arbiter: per-port packet sources, scoreboard of expected
// header/data beats in grant order, table of round-robin vectors, and multi-cycle corner sequences.
module tb_turf_udp_tx_arbiter;

    localparam int N = 4;
    localparam int P = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [64*N-1:0] s_hdr_tdata;
    logic [16*N-1:0] s_hdr_tuser;
    logic [N-1:0]    s_hdr_tvalid;
    logic [N-1:0]    s_hdr_tready;
    logic [64*N-1:0] s_data_tdata;
    logic [8*N-1:0]  s_data_tkeep;
    logic [N-1:0]    s_data_tlast;
    logic [N-1:0]    s_data_tvalid;
    logic [N-1:0]    s_data_tready;
    logic [63:0]     m_udphdr_tdata;
    logic [15:0]     m_udphdr_tuser;
    logic            m_udphdr_tvalid;
    logic            m_udphdr_tready;
    logic [63:0]     m_udpdata_tdata;
    logic [7:0]      m_udpdata_tkeep;
    logic            m_udpdata_tlast;
    logic            m_udpdata_tvalid;
    logic            m_udpdata_tready;
    logic [P-1:0]    grant_idx;
    logic            busy;
`ifdef TURF_UDP_ARB_STATS_EN
    logic [32*N-1:0] pkt_count;
`endif

    turf_udp_tx_arbiter #(.NUM_PORTS(N), .PTR_BITS(P)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .s_hdr_tdata      (s_hdr_tdata),
        .s_hdr_tuser      (s_hdr_tuser),
        .s_hdr_tvalid     (s_hdr_tvalid),
        .s_hdr_tready     (s_hdr_tready),
        .s_data_tdata     (s_data_tdata),
        .s_data_tkeep     (s_data_tkeep),
        .s_data_tlast     (s_data_tlast),
        .s_data_tvalid    (s_data_tvalid),
        .s_data_tready    (s_data_tready),
        .m_udphdr_tdata   (m_udphdr_tdata),
        .m_udphdr_tuser   (m_udphdr_tuser),
        .m_udphdr_tvalid  (m_udphdr_tvalid),
        .m_udphdr_tready  (m_udphdr_tready),
        .m_udpdata_tdata  (m_udpdata_tdata),
        .m_udpdata_tkeep  (m_udpdata_tkeep),
        .m_udpdata_tlast  (m_udpdata_tlast),
        .m_udpdata_tvalid (m_udpdata_tvalid),
        .m_udpdata_tready (m_udpdata_tready),
        .grant_idx        (grant_idx),
        .busy             (busy)
`ifdef TURF_UDP_ARB_STATS_EN
        ,
        .pkt_count        (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] hdr;
        logic [15:0] user;
        int          nb;
        logic [63:0] base;
        logic [7:0]  kl;
    } pkt_t;

    typedef struct {
        int          port;
        bit          is_hdr;
        logic [63:0] data;
        logic [15:0] user;
        logic [7:0]  keep;
        bit          last;
    } exp_t;

    typedef struct {
        int          port;
        logic [31:0] ip;
        logic [15:0] dport;
        int          nb;
        logic [7:0]  kl;
        int          exp_grant;
    } vec_t;

    pkt_t pq[N][$];
    exp_t sb[$];
    int   gorder[$];
    int   ph[N];
    int   bt[N];
    bit   hf[N];
    bit   df[N];
    int   rmode = 0;
    bit   tog = 1'b0;
    bit   gap_en = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   dbeats = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, expv);
        end
    endtask

    task automatic add(input int p, input logic [31:0] ip, input logic [15:0] dp,
                       input logic [15:0] len, input int nb, input logic [7:0] kl);
        pkt_t k;
        exp_t e;
        k.hdr  = {ip, dp, len};
        k.user = 16'h1000 + 16'(p);
        k.nb   = nb;
        k.base = {ip, 32'h0} + 64'(p << 8);
        k.kl   = kl;
        pq[p].push_back(k);
        e.port = p; e.is_hdr = 1'b1; e.data = k.hdr; e.user = k.user;
        e.keep = 8'h00; e.last = 1'b0;
        sb.push_back(e);
        for (int b = 0; b < nb; b++) begin
            e.is_hdr = 1'b0;
            e.data   = k.base + 64'(b);
            e.user   = 16'h0;
            e.keep   = (b == nb - 1) ? kl : 8'hFF;
            e.last   = (b == nb - 1);
            sb.push_back(e);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            if (pq[p].size() > 0) begin
                s_hdr_tvalid[p]           = (ph[p] == 0);
                s_hdr_tdata[64*p +: 64]   = pq[p][0].hdr;
                s_hdr_tuser[16*p +: 16]   = pq[p][0].user;
                s_data_tvalid[p]          = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                s_data_tdata[64*p +: 64]  = pq[p][0].base + 64'(bt[p]);
                s_data_tlast[p]           = (bt[p] == pq[p][0].nb - 1);
                s_data_tkeep[8*p +: 8]    = s_data_tlast[p] ? pq[p][0].kl : 8'hFF;
            end else begin
                s_hdr_tvalid[p]           = 1'b0;
                s_hdr_tdata[64*p +: 64]   = '0;
                s_hdr_tuser[16*p +: 16]   = '0;
                s_data_tvalid[p]          = 1'b0;
                s_data_tdata[64*p +: 64]  = '0;
                s_data_tlast[p]           = 1'b0;
                s_data_tkeep[8*p +: 8]    = '0;
            end
        end
    endtask

    task automatic flush();
        for (int p = 0; p < N; p++) begin
            pq[p].delete();
            ph[p] = 0; bt[p] = 0; hf[p] = 1'b0; df[p] = 1'b0;
        end
        sb.delete();
        gorder.delete();
        dbeats = 0;
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        flush();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain(input string nm, input int budget);
        int c = 0;
        while (sb.size() > 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        repeat (2) @(posedge clk);
        chk(nm, 64'(sb.size()), 64'd0);
    endtask

    // Source model: apply handshakes seen in the previous cycle, then present next values.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < N; p++) begin
                if (hf[p]) ph[p] = 1;
                if (df[p] && pq[p].size() > 0) begin
                    if (bt[p] == pq[p][0].nb - 1) begin
                        void'(pq[p].pop_front());
                        ph[p] = 0;
                        bt[p] = 0;
                    end else begin
                        bt[p]++;
                    end
                end
                hf[p] = 1'b0;
                df[p] = 1'b0;
            end
            tog = ~tog;
            m_udphdr_tready  = (rmode != 2);
            m_udpdata_tready = (rmode == 1) ? tog : 1'b1;
            drive();
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int p = 0; p < N; p++) begin
                if (s_hdr_tready[p] || s_data_tready[p]) begin
                    bit ok;
                    ok = (sb.size() > 0);
                    if (ok) ok = (sb[0].port == p) &&
                                 !(s_data_tready[p] && sb[0].is_hdr) &&
                                 !(s_hdr_tready[p] && !sb[0].is_hdr);
                    total++;
                    if (!ok) begin
                        bad++;
                        $display("FAIL ready_owner: got port %0d hdr_rdy=%0b data_rdy=%0b want none",
                                 p, s_hdr_tready[p], s_data_tready[p]);
                    end
                end
                hf[p] = s_hdr_tvalid[p] && s_hdr_tready[p];
                df[p] = s_data_tvalid[p] && s_data_tready[p];
            end
            if (m_udphdr_tvalid && m_udphdr_tready) begin
                gorder.push_back(int'(grant_idx));
                if (sb.size() == 0 || !sb[0].is_hdr) begin
                    total++; bad++;
                    $display("FAIL hdr_unexpected: got %h want data or nothing", m_udphdr_tdata);
                end else begin
                    chk("hdr_data", m_udphdr_tdata, sb[0].data);
                    chk("hdr_user", 64'(m_udphdr_tuser), 64'(sb[0].user));
                    chk("hdr_grant", 64'(grant_idx), 64'(sb[0].port));
                    void'(sb.pop_front());
                end
            end
            if (m_udpdata_tvalid && m_udpdata_tready) begin
                dbeats++;
                if (sb.size() == 0 || sb[0].is_hdr) begin
                    total++; bad++;
                    $display("FAIL data_unexpected: got %h want header or nothing", m_udpdata_tdata);
                end else begin
                    chk("data", m_udpdata_tdata, sb[0].data);
                    chk("keep", 64'(m_udpdata_tkeep), 64'(sb[0].keep));
                    chk("last", 64'(m_udpdata_tlast), 64'(sb[0].last));
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic chk_idle(input string nm);
        chk({nm, "_busy"}, 64'(busy), 64'd0);
        chk({nm, "_grant"}, 64'(grant_idx), 64'd0);
        chk({nm, "_hvalid"}, 64'(m_udphdr_tvalid), 64'd0);
        chk({nm, "_dvalid"}, 64'(m_udpdata_tvalid), 64'd0);
        chk({nm, "_ddata"}, m_udpdata_tdata, 64'd0);
        chk({nm, "_hdata"}, m_udphdr_tdata, 64'd0);
        chk({nm, "_ready"}, 64'({s_hdr_tready, s_data_tready}), 64'd0);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{0, 32'h0A000001, 16'd1000, 1, 8'h01, 0};
        tbl[1] = '{1, 32'h0A000002, 16'd1001, 1, 8'h03, 1};
        tbl[2] = '{2, 32'h0A000003, 16'd1002, 1, 8'h07, 2};
        tbl[3] = '{3, 32'h0A000004, 16'd1003, 1, 8'h0F, 3};
        tbl[4] = '{0, 32'h0A000005, 16'd1004, 1, 8'h1F, 0};
        tbl[5] = '{1, 32'h0A000006, 16'd1005, 1, 8'h3F, 1};
        tbl[6] = '{2, 32'h0A000007, 16'd1006, 1, 8'h7F, 2};
        tbl[7] = '{3, 32'h0A000008, 16'd1007, 1, 8'hFF, 3};

        m_udphdr_tready  = 1'b1;
        m_udpdata_tready = 1'b1;
        flush();
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester on port 2, arbitration latency
        add(2, 32'hC0A8010A, 16'd5000, 16'd24, 3, 8'hFF);
        @(posedge clk);
        #2;
        chk("t1_src_valid", 64'(s_hdr_tvalid), 64'h4);
        @(negedge clk);
        chk("t1_hvalid_early", 64'(m_udphdr_tvalid), 64'd0);
        @(negedge clk);
        chk("t1_hvalid", 64'(m_udphdr_tvalid), 64'd1);
        chk("t1_grant", 64'(grant_idx), 64'd2);
        drain("t1_drain", 50);

        // Round-robin with all ports requesting
        do_reset();
        for (int i = 0; i < 8; i++) begin
            add(tbl[i].port, tbl[i].ip, tbl[i].dport, 16'd8, tbl[i].nb, tbl[i].kl);
        end
        drain("t2_drain", 200);
        chk("t2_count", 64'(gorder.size()), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < gorder.size()) chk("t2_order", 64'(gorder[i]), 64'(tbl[i].exp_grant));
        end

        // Port 0 requests while port 1 is mid-packet, toggling downstream ready and gappy sources
        do_reset();
        rmode  = 1;
        gap_en = 1'b1;
        add(1, 32'hC0A80101, 16'd6000, 16'd40, 5, 8'h0F);
        begin
            int c = 0;
            while (!(busy && dbeats >= 1) && c < 100) begin
                @(posedge clk);
                #3;
                c++;
            end
            chk("t3_reach_data", 64'(dbeats >= 1), 64'd1);
        end
        add(0, 32'hC0A80102, 16'd6001, 16'd16, 2, 8'hF0);
        drain("t3_drain", 300);
        chk("t3_order_n", 64'(gorder.size()), 64'd2);
        if (gorder.size() == 2) begin
            chk("t3_first", 64'(gorder[0]), 64'd1);
            chk("t3_second", 64'(gorder[1]), 64'd0);
        end
        rmode  = 0;
        gap_en = 1'b0;

        // Reset mid-packet, then port 0 regains priority
        do_reset();
        add(2, 32'hC0A80201, 16'd7000, 16'd40, 5, 8'hFF);
        begin
            int c = 0;
            while (dbeats < 2 && c < 100) begin
                @(posedge clk);
                #3;
                c++;
            end
            chk("t4_reach_beat2", 64'(dbeats), 64'd2);
        end
        rst_n = 1'b0;
        #1;
        chk_idle("t4_async");
        @(posedge clk);
        #2;
        flush();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        add(0, 32'hC0A80301, 16'd7100, 16'd8, 1, 8'hFF);
        add(3, 32'hC0A80302, 16'd7101, 16'd16, 2, 8'h01);
        drain("t4_drain", 100);
        chk("t4_order_n", 64'(gorder.size()), 64'd2);
        if (gorder.size() == 2) begin
            chk("t4_first", 64'(gorder[0]), 64'd0);
            chk("t4_second", 64'(gorder[1]), 64'd3);
        end

        // Header stall holds header stable and blocks payload
        do_reset();
        rmode = 2;
        add(1, 32'hC0A80401, 16'd8000, 16'd16, 2, 8'h3F);
        begin
            int c = 0;
            @(negedge clk);
            while (!m_udphdr_tvalid && c < 20) begin
                @(negedge clk);
                c++;
            end
            for (int i = 0; i < 10; i++) begin
                chk("t5_hvalid", 64'(m_udphdr_tvalid), 64'd1);
                chk("t5_hdata", m_udphdr_tdata, {32'hC0A80401, 16'd8000, 16'd16});
                chk("t5_dready", 64'(s_data_tready), 64'd0);
                chk("t5_dvalid_out", 64'(m_udpdata_tvalid), 64'd0);
                @(negedge clk);
            end
        end
        rmode = 0;
        drain("t5_drain", 50);

`ifdef TURF_UDP_ARB_STATS_EN
        do_reset();
        add(0, 32'hC0A80501, 16'd9000, 16'd8, 1, 8'hFF);
        add(3, 32'hC0A80502, 16'd9001, 16'd8, 1, 8'hFF);
        add(3, 32'hC0A80503, 16'd9002, 16'd16, 2, 8'hFF);
        add(3, 32'hC0A80504, 16'd9003, 16'd8, 1, 8'h0F);
        drain("t6_drain", 100);
        chk("t6_cnt3", 64'(pkt_count[96 +: 32]), 64'd3);
        chk("t6_cnt0", 64'(pkt_count[0 +: 32]), 64'd1);
        chk("t6_cnt1", 64'(pkt_count[32 +: 32]), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
